clk_period_meter: RTL

//  Measures an asynchronous slow clock (e.g. the divided_clk output of a
//  clk_divider) in clk_in cycles. It reports the full period and the high time
//  of one cycle, so firmware and bench logic can check a divider's ratio at

---
 rtl/clk_meas_pkg.sv | 21 ++
 rtl/sync_edge_det.sv | 32 +++
 rtl/clk_period_meter.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/clk_meas_pkg.sv
// Shared definitions for the clock period meter: FSM state encoding and
// default sizing used by clk_period_meter and its bench.
package clk_meas_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_MEAS = 2'd2,
        ST_DONE = 2'd3
    } meas_state_e;

    localparam int unsigned CNT_W_DEF       = 32;
    localparam int unsigned TIMEOUT_DEF     = 10_000_000;
    localparam int unsigned SYNC_STAGES_DEF = 2;

    // Width of a counter that must reach max_val - 1 (at least one bit).
    function automatic int unsigned tmo_width(input int unsigned max_val);
        return (max_val > 1) ? $clog2(max_val) : 1;
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous input followed by a one-cycle
// rise/fall detector on the synchronized level.
module sync_edge_det #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic async_i,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              last_q;

    // NOTE: flops take non-blocking assignments so every register samples the
    // pre-edge value of its neighbour, which is what makes the shift chain work.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            last_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_i};
            last_q <= sync_q[STAGES-1];
        end
    end

    // Edges are flagged in the cycle the new level leaves the synchronizer.
    assign rise_o = sync_q[STAGES-1] & ~last_q;
    assign fall_o = ~sync_q[STAGES-1] & last_q;

endmodule

// File: rtl/clk_period_meter.sv
// Measures period and high time of an asynchronous slow clock in clk_in
// cycles, returning the result through a valid/ready handshake.
module clk_period_meter
    import clk_meas_pkg::*;
#(
    parameter int unsigned CNT_W       = CNT_W_DEF,
    parameter int unsigned TIMEOUT     = TIMEOUT_DEF,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             sig_in,
    input  logic             start,
    output logic             busy,
    output logic             meas_valid,
    input  logic             meas_ready,
    output logic [CNT_W-1:0] period_cnt,
    output logic [CNT_W-1:0] high_cnt,
    output logic             timeout
);

    localparam int unsigned      TMO_W    = tmo_width(TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    meas_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [CNT_W-1:0] high_acc_q, high_acc_d;
    logic             high_seen_q, high_seen_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic             timeout_q, timeout_d;

    logic             sig_rise;
    logic             sig_fall;
    logic             tmo_hit;
    logic [CNT_W-1:0] cnt_inc;

    sync_edge_det #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_in  (clk_in),
        .rst_n   (rst_n),
        .async_i (sig_in),
        .rise_o  (sig_rise),
        .fall_o  (sig_fall)
    );

    assign tmo_hit = (tmo_q == TMO_LAST);
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

    // NOTE: every _d gets its hold value first so no path through the case
    // leaves a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tmo_d       = tmo_q;
        high_acc_d  = high_acc_q;
        high_seen_d = high_seen_q;
        period_d    = period_q;
        high_d      = high_q;
        timeout_d   = timeout_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_ARM;
                    cnt_d       = '0;
                    tmo_d       = '0;
                    high_acc_d  = '0;
                    high_seen_d = 1'b0;
                end
            end

            ST_ARM: begin
                tmo_d = tmo_q + TMO_W'(1);
                if (tmo_hit) begin
                    state_d   = ST_DONE;
                    timeout_d = 1'b1;
                    period_d  = '0;
                    high_d    = '0;
                end else if (sig_rise) begin
                    state_d = ST_MEAS;
                    cnt_d   = CNT_ONE;
                end
            end

            ST_MEAS: begin
                tmo_d = tmo_q + TMO_W'(1);
                cnt_d = cnt_inc;
                if (sig_fall && !high_seen_q) begin
                    high_acc_d  = cnt_q;
                    high_seen_d = 1'b1;
                end
                // Timeout outranks a rise landing in the same cycle.
                if (tmo_hit) begin
                    state_d   = ST_DONE;
                    timeout_d = 1'b1;
                    period_d  = '0;
                    high_d    = '0;
                end else if (sig_rise) begin
                    state_d   = ST_DONE;
                    timeout_d = 1'b0;
                    period_d  = cnt_q;
                    high_d    = high_acc_q;
                end
            end

            ST_DONE: begin
                if (meas_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            tmo_q       <= '0;
            high_acc_q  <= '0;
            high_seen_q <= 1'b0;
            period_q    <= '0;
            high_q      <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            high_acc_q  <= high_acc_d;
            high_seen_q <= high_seen_d;
            period_q    <= period_d;
            high_q      <= high_d;
            timeout_q   <= timeout_d;
        end
    end

    assign busy       = (state_q != ST_IDLE);
    assign meas_valid = (state_q == ST_DONE);
    assign period_cnt = period_q;
    assign high_cnt   = high_q;
    assign timeout    = timeout_q;

endmodule
